// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write port driver:
// load type codes, partial-word byte-enable tables and the pending-load entry.
package wb_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        LWL = 3'd5,
        LWR = 3'd6
    } ld_type_e;

    // Indexed by address bits [1:0]
    localparam logic [3:0][3:0] LWL_WE = {4'b1111, 4'b1110, 4'b1100, 4'b1000};
    localparam logic [3:0][3:0] LWR_WE = {4'b0001, 4'b0011, 4'b0111, 4'b1111};

    typedef struct packed {
        logic [4:0] wr;
        ld_type_e   ltype;
        logic [1:0] off;
    } ld_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks, extends or shifts the memory word and
// produces the byte-lane enables for a partial-word register write.
module wb_load_align
    import wb_pkg::*;
(
    input  ld_type_e    ltype,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [3:0]  we,
    output logic [31:0] wd
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(data >> {off, 3'b000});
        // Misaligned halves never reach here, so only off[1] matters
        half_sel = off[1] ? data[31:16] : data[15:0];
        we       = 4'b0000;
        wd       = data;
        case (ltype)
            LB:  begin we = 4'b1111; wd = {{24{byte_sel[7]}}, byte_sel}; end
            LBU: begin we = 4'b1111; wd = {24'h0, byte_sel}; end
            LH:  begin we = 4'b1111; wd = {{16{half_sel[15]}}, half_sel}; end
            LHU: begin we = 4'b1111; wd = {16'h0, half_sel}; end
            LW:  begin we = 4'b1111; wd = data; end
            LWL: begin we = LWL_WE[off]; wd = data << {~off, 3'b000}; end
            LWR: begin we = LWR_WE[off]; wd = data >> {off, 3'b000}; end
            default: we = 4'b0000;
        endcase
    end

endmodule

// File: rtl/wb_port_writer.sv
// Register-file write port driver: merges ALU results with in-order load
// responses, aligns load data and flags read-after-write hazards for decode.
module wb_port_writer
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_wr,
    input  logic [31:0] alu_wd,
    input  logic        ld_issue_valid,
    output logic        ld_issue_ready,
    input  logic [4:0]  ld_issue_wr,
    input  logic [2:0]  ld_issue_type,
    input  logic [1:0]  ld_issue_off,
    input  logic        ld_resp_valid,
    input  logic [31:0] ld_resp_data,
    input  logic [4:0]  hz_rr1,
    input  logic [4:0]  hz_rr2,
    output logic        hz_stall1,
    output logic        hz_stall2,
    output logic        err_orphan,
    output logic [3:0]  reg_we,
    output logic [4:0]  WR,
    output logic [31:0] WD
);

    localparam int AW = $clog2(DEPTH);

    ld_entry_t        q [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             empty, full, push, pop, alu_fire;
    ld_entry_t        head;
    logic [3:0]       al_we;
    logic [31:0]      al_wd;

    // Slots fill and drain in order, so the head/tail slot valid bits give empty/full
    assign empty          = !valid[rd_ptr];
    assign full           = valid[wr_ptr];
    assign ld_issue_ready = !full;
    assign push           = ld_issue_valid && !full;
    assign pop            = ld_resp_valid && !empty;
    assign alu_ready      = !pop;
    assign alu_fire       = alu_valid && alu_ready;
    assign head           = q[rd_ptr];

    wb_load_align u_align (
        .ltype (head.ltype),
        .off   (head.off),
        .data  (ld_resp_data),
        .we    (al_we),
        .wd    (al_wd)
    );

    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= '{wr: ld_issue_wr, ltype: ld_type_e'(ld_issue_type), off: ld_issue_off};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_we     <= '0;
            WR         <= '0;
            WD         <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (pop) begin
                reg_we <= (head.wr != '0) ? al_we : 4'b0000;
                WR     <= head.wr;
                WD     <= al_wd;
            end else if (alu_fire) begin
                reg_we <= (alu_wr != '0) ? 4'b1111 : 4'b0000;
                WR     <= alu_wr;
                WD     <= alu_wd;
            end else begin
                reg_we <= '0;
            end
            if (ld_resp_valid && empty) err_orphan <= 1'b1;
        end
    end

    // Pending writes: every queued load plus the uncommitted output stage
    always_comb begin
        hz_stall1 = 1'b0;
        hz_stall2 = 1'b0;
        if (reg_we != '0) begin
            if (WR == hz_rr1) hz_stall1 = 1'b1;
            if (WR == hz_rr2) hz_stall2 = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && q[i].wr == hz_rr1) hz_stall1 = 1'b1;
            if (valid[i] && q[i].wr == hz_rr2) hz_stall2 = 1'b1;
        end
        if (hz_rr1 == '0) hz_stall1 = 1'b0;
        if (hz_rr2 == '0) hz_stall2 = 1'b0;
    end

endmodule

// File: tb/tb_wb_port_writer.sv
// Directed bench for wb_port_writer: ALU writes, load alignment, queue
// full/order, arbitration, hazards, orphans and reset mid-queue.
module tb_wb_port_writer;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_wr;
    logic [31:0] alu_wd;
    logic        ld_issue_valid, ld_issue_ready;
    logic [4:0]  ld_issue_wr;
    logic [2:0]  ld_issue_type;
    logic [1:0]  ld_issue_off;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic [4:0]  hz_rr1, hz_rr2;
    logic        hz_stall1, hz_stall2, err_orphan;
    logic [3:0]  reg_we;
    logic [4:0]  WR;
    logic [31:0] WD;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_port_writer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wr(alu_wr), .alu_wd(alu_wd),
        .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready),
        .ld_issue_wr(ld_issue_wr), .ld_issue_type(ld_issue_type), .ld_issue_off(ld_issue_off),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .hz_rr1(hz_rr1), .hz_rr2(hz_rr2), .hz_stall1(hz_stall1), .hz_stall2(hz_stall2),
        .err_orphan(err_orphan), .reg_we(reg_we), .WR(WR), .WD(WD)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] wr, input ld_type_e t, input logic [1:0] off);
        ld_issue_valid = 1'b1; ld_issue_wr = wr; ld_issue_type = t; ld_issue_off = off;
        step();
        ld_issue_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        ld_resp_valid = 1'b1; ld_resp_data = d;
        step();
        ld_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_valid = 0; alu_wr = 0; alu_wd = 0;
        ld_issue_valid = 0; ld_issue_wr = 0; ld_issue_type = 0; ld_issue_off = 0;
        ld_resp_valid = 0; ld_resp_data = 0; hz_rr1 = 5'd5; hz_rr2 = 0;
        step(); step();
        rst_n = 1'b1;
        #1;
        checks++; if (reg_we !== 4'h0) begin failures++; $display("FAIL rst_we got %h exp 0", reg_we); end
        checks++; if (WR !== 5'd0) begin failures++; $display("FAIL rst_wr got %h exp 0", WR); end
        checks++; if (WD !== 32'h0) begin failures++; $display("FAIL rst_wd got %h exp 0", WD); end
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL rst_orphan got %b exp 0", err_orphan); end
        checks++; if (ld_issue_ready !== 1'b1) begin failures++; $display("FAIL rst_issue_ready got %b exp 1", ld_issue_ready); end
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL rst_alu_ready got %b exp 1", alu_ready); end
        checks++; if (hz_stall1 !== 1'b0) begin failures++; $display("FAIL rst_stall1 got %b exp 0", hz_stall1); end
    endtask

    task automatic test_alu();
        alu_valid = 1; alu_wr = 5'd5; alu_wd = 32'h1234_5678;
        step();
        alu_valid = 0;
        #1;
        checks++; if (reg_we !== 4'hF) begin failures++; $display("FAIL alu_we got %h exp f", reg_we); end
        checks++; if (WR !== 5'd5) begin failures++; $display("FAIL alu_wr got %h exp 5", WR); end
        checks++; if (WD !== 32'h1234_5678) begin failures++; $display("FAIL alu_wd got %h exp 12345678", WD); end
        hz_rr1 = 5'd5; #1;
        checks++; if (hz_stall1 !== 1'b1) begin failures++; $display("FAIL alu_out_stall got %b exp 1", hz_stall1); end
        step();
        checks++; if (reg_we !== 4'h0) begin failures++; $display("FAIL idle_we got %h exp 0", reg_we); end
        checks++; if (WR !== 5'd5 || WD !== 32'h1234_5678) begin failures++; $display("FAIL idle_hold got %h/%h exp 5/12345678", WR, WD); end
        checks++; if (hz_stall1 !== 1'b0) begin failures++; $display("FAIL idle_stall got %b exp 0", hz_stall1); end
        alu_valid = 1; alu_wr = 5'd0; alu_wd = 32'hDEAD_BEEF;
        step();
        alu_valid = 0;
        checks++; if (reg_we !== 4'h0) begin failures++; $display("FAIL alu_r0_we got %h exp 0", reg_we); end
        hz_rr1 = 0;
    endtask

    task automatic test_align();
        issue(5'd3, LB, 2'd2);
        respond(32'h0080_0000);
        checks++; if (reg_we !== 4'hF || WR !== 5'd3 || WD !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb got %h/%h/%h exp f/03/ffffff80", reg_we, WR, WD); end
        issue(5'd3, LBU, 2'd2);
        respond(32'h0080_0000);
        checks++; if (reg_we !== 4'hF || WD !== 32'h0000_0080) begin failures++; $display("FAIL lbu got %h/%h exp f/00000080", reg_we, WD); end
        issue(5'd4, LH, 2'd2);
        respond(32'h8001_0000);
        checks++; if (reg_we !== 4'hF || WD !== 32'hFFFF_8001) begin failures++; $display("FAIL lh got %h/%h exp f/ffff8001", reg_we, WD); end
        issue(5'd4, LHU, 2'd3);
        respond(32'h8001_0000);
        checks++; if (reg_we !== 4'hF || WD !== 32'h0000_8001) begin failures++; $display("FAIL lhu got %h/%h exp f/00008001", reg_we, WD); end
        issue(5'd7, LWL, 2'd1);
        respond(32'hAABB_CCDD);
        checks++; if (reg_we !== 4'b1100 || WD[31:16] !== 16'hCCDD) begin failures++; $display("FAIL lwl got %b/%h exp 1100/ccdd", reg_we, WD[31:16]); end
        issue(5'd8, LWR, 2'd2);
        respond(32'hAABB_CCDD);
        checks++; if (reg_we !== 4'b0011 || WD[15:0] !== 16'hAABB) begin failures++; $display("FAIL lwr got %b/%h exp 0011/aabb", reg_we, WD[15:0]); end
        issue(5'd9, ld_type_e'(3'd7), 2'd0);
        respond(32'h1111_1111);
        checks++; if (reg_we !== 4'b0000) begin failures++; $display("FAIL undef_type got %b exp 0000", reg_we); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        ld_issue_valid = 1; ld_issue_type = LW; ld_issue_off = 0;
        for (int i = 0; i < 4; i++) begin
            ld_issue_wr = 5'(10 + i);
            step();
        end
        ld_issue_valid = 0;
        #1;
        checks++; if (ld_issue_ready !== 1'b0) begin failures++; $display("FAIL full_ready got %b exp 0", ld_issue_ready); end
        // 5th issue alongside a response must be refused
        ld_issue_valid = 1; ld_issue_wr = 5'd14; ld_resp_valid = 1; ld_resp_data = 32'h1000_0000;
        #1;
        checks++; if (ld_issue_ready !== 1'b0) begin failures++; $display("FAIL full_pop_ready got %b exp 0", ld_issue_ready); end
        step();
        ld_issue_valid = 0; ld_resp_valid = 0;
        #1;
        checks++; if (WR !== 5'd10 || WD !== 32'h1000_0000 || reg_we !== 4'hF) begin failures++; $display("FAIL order0 got %h/%h exp 0a/10000000", WR, WD); end
        checks++; if (ld_issue_ready !== 1'b1) begin failures++; $display("FAIL after_pop_ready got %b exp 1", ld_issue_ready); end
        hz_rr2 = 5'd14; #1;
        checks++; if (hz_stall2 !== 1'b0) begin failures++; $display("FAIL refused_stall got %b exp 0", hz_stall2); end
        hz_rr2 = 0;
        for (int i = 1; i < 4; i++) begin
            exp_d = 32'h1000_0000 * (i + 1);
            respond(exp_d);
            checks++; if (WR !== 5'(10 + i) || WD !== exp_d) begin failures++; $display("FAIL order%0d got %h/%h exp %h/%h", i, WR, WD, 5'(10 + i), exp_d); end
        end
        step();
    endtask

    task automatic test_arb_hazard();
        issue(5'd20, LW, 2'd0);
        hz_rr1 = 5'd20; #1;
        checks++; if (hz_stall1 !== 1'b1) begin failures++; $display("FAIL queued_stall got %b exp 1", hz_stall1); end
        ld_resp_valid = 1; ld_resp_data = 32'hCAFE_0001;
        alu_valid = 1; alu_wr = 5'd21; alu_wd = 32'hBEEF_0002;
        // concurrent push while non-empty
        ld_issue_valid = 1; ld_issue_wr = 5'd22; ld_issue_type = LW; ld_issue_off = 0;
        #1;
        checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL arb_alu_ready got %b exp 0", alu_ready); end
        step();
        ld_resp_valid = 0; ld_issue_valid = 0;
        #1;
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL arb_alu_ready2 got %b exp 1", alu_ready); end
        checks++; if (reg_we !== 4'hF || WR !== 5'd20 || WD !== 32'hCAFE_0001) begin failures++; $display("FAIL arb_load_first got %h/%h/%h exp f/14/cafe0001", reg_we, WR, WD); end
        checks++; if (hz_stall1 !== 1'b1) begin failures++; $display("FAIL out_stage_stall got %b exp 1", hz_stall1); end
        step();
        alu_valid = 0;
        hz_rr2 = 5'd21; #1;
        checks++; if (reg_we !== 4'hF || WR !== 5'd21 || WD !== 32'hBEEF_0002) begin failures++; $display("FAIL arb_alu_next got %h/%h/%h exp f/15/beef0002", reg_we, WR, WD); end
        checks++; if (hz_stall1 !== 1'b0) begin failures++; $display("FAIL committed_stall got %b exp 0", hz_stall1); end
        checks++; if (hz_stall2 !== 1'b1) begin failures++; $display("FAIL stall2 got %b exp 1", hz_stall2); end
        hz_rr1 = 5'd22; #1;
        checks++; if (hz_stall1 !== 1'b1) begin failures++; $display("FAIL pushpop_stall got %b exp 1", hz_stall1); end
        respond(32'h0000_0022);
        checks++; if (WR !== 5'd22 || WD !== 32'h22) begin failures++; $display("FAIL pushpop_wr got %h/%h exp 16/22", WR, WD); end
        hz_rr1 = 0; hz_rr2 = 0;
        step();
    endtask

    task automatic test_orphan();
        ld_resp_valid = 1; ld_resp_data = 32'h5555_5555;
        ld_issue_valid = 1; ld_issue_wr = 5'd25; ld_issue_type = LW; ld_issue_off = 0;
        step();
        ld_resp_valid = 0; ld_issue_valid = 0;
        checks++; if (err_orphan !== 1'b1 || reg_we !== 4'h0) begin failures++; $display("FAIL orphan got %b/%h exp 1/0", err_orphan, reg_we); end
        respond(32'h0000_0025);
        checks++; if (reg_we !== 4'hF || WR !== 5'd25 || WD !== 32'h25) begin failures++; $display("FAIL after_orphan got %h/%h/%h exp f/19/25", reg_we, WR, WD); end
        checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky got %b exp 1", err_orphan); end
    endtask

    task automatic test_reset_mid();
        issue(5'd26, LW, 2'd0);
        issue(5'd27, LW, 2'd0);
        rst_n = 0; ld_resp_valid = 1; ld_resp_data = 32'h2626_2626;
        step();
        rst_n = 1; ld_resp_valid = 0;
        hz_rr1 = 5'd26; hz_rr2 = 5'd27; #1;
        checks++; if (reg_we !== 4'h0 || err_orphan !== 1'b0) begin failures++; $display("FAIL rst_mid got %h/%b exp 0/0", reg_we, err_orphan); end
        checks++; if (hz_stall1 !== 1'b0 || hz_stall2 !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got %b%b exp 00", hz_stall1, hz_stall2); end
        respond(32'h2727_2727);
        checks++; if (err_orphan !== 1'b1 || reg_we !== 4'h0) begin failures++; $display("FAIL rst_mid_orphan got %b/%h exp 1/0", err_orphan, reg_we); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_align();
        test_back_to_back();
        test_arb_hazard();
        test_orphan();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_writer.md
Name: wb_port_writer

Overview:
- Driver for the general register file write port. It produces the byte-lane enables, the write address and the write data that the register file consumes.
- Merges two writeback sources: ALU results, and load data returning from data memory. Each load is tracked from issue to response in an in-order pending queue.
- Aligns load data for LB/LBU/LH/LHU/LW/LWL/LWR so that partial-word loads use the register file's byte-lane write enables.
- Supplies hazard stall flags for the decode stage's two read ports.

Parameters:
- DEPTH, 4, number of outstanding loads in the pending queue (power of 2, at least 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_wr  in  5  ALU destination register
- alu_wd  in  32  ALU result
- ld_issue_valid  in  1  load issued to memory
- ld_issue_ready  out  1  pending queue can accept an issue
- ld_issue_wr  in  5  load destination register
- ld_issue_type  in  3  load type code (package)
- ld_issue_off  in  2  address bits [1:0]
- ld_resp_valid  in  1  memory data valid; responses arrive in issue order
- ld_resp_data  in  32  aligned memory word
- hz_rr1  in  5  decode read address 1
- hz_rr2  in  5  decode read address 2
- hz_stall1  out  1  hz_rr1 has a pending write
- hz_stall2  out  1  hz_rr2 has a pending write
- err_orphan  out  1  sticky: a response arrived with the queue empty
- reg_we  out  4  byte-lane write enables to the register file
- WR  out  5  write address
- WD  out  32  write data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: reg_we=0, WR=0, WD=0, err_orphan=0, queue empty.
- Ready signals: ld_issue_ready=!full and alu_ready=1 after reset, because both are combinational.
- Output stage: reg_we/WR/WD are registered. A write accepted in cycle N appears in cycle N+1 and is committed by the register file at the edge ending N+1. When nothing is accepted, reg_we=0 and WR/WD hold their previous values.
- Queue: in-order FIFO. Each entry holds {wr, type, off}.
  - Push on ld_issue_valid && ld_issue_ready.
  - Pop on ld_resp_valid && !empty.
  - ld_issue_ready=!full, with no same-cycle bypass: when full, an issue is refused even if a pop occurs that cycle.
  - Push and pop in the same cycle are both legal when the queue is neither full nor empty.
- Orphan responses: a response while the queue is empty is dropped, no write is produced, and err_orphan sets. A push in that same cycle does not match the response. err_orphan clears only on reset.
- Arbitration: a load response has priority. alu_ready = !(ld_resp_valid && !empty). A stalled ALU holds its values.
- Register zero: destination 0 produces reg_we=0 and consumes the source normally.
- Alignment, off = a:
  - LW: we=1111, WD=data.
  - LB/LBU: byte data[8a+7:8a], sign- or zero-extended, we=1111.
  - LH/LHU: half selected by a[1], sign- or zero-extended, we=1111. Bit a[0] is ignored because misalignment is trapped upstream.
  - LWL: we = {1000, 1100, 1110, 1111} for a = 0..3; WD = data << 8*(3-a).
  - LWR: we = {1111, 0111, 0011, 0001} for a = 0..3; WD = data >> 8*a.
  - Undefined type codes: we=0000.
- Hazards: hz_stallX=1 when hz_rrX!=0 and it equals either of the following:
  - the wr of any valid queue entry;
  - WR while reg_we!=0 (the output-stage write is not yet committed).
  - Flags are combinational from current state. They do not include ALU results still in flight upstream.
- Reset mid-operation: all queue entries are discarded, so later responses become orphans. Any write in the output stage is suppressed.

Decomposition:
- Package wb_pkg holds:
  - load type encodings: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6;
  - the LWL/LWR byte-enable lookup constants;
  - the queue entry struct {wr, type, off}.
- Sub-module wb_load_align: purely combinational. Takes (type, off, data) and returns (we, wd). It is reused by any future store-path aligner.

Test Plan:
- Reset, then ALU write alu_wr=5, alu_wd=32'h1234_5678 -> next cycle reg_we=1111, WR=5, WD=32'h1234_5678; alu_wr=0 -> reg_we=0000.
- Issue LB wr=3 off=2, then response 32'h0080_0000 -> WD=32'hFFFF_FF80, we=1111. Repeat as LBU -> WD=32'h0000_0080.
- LWL off=1 with data 32'hAABB_CCDD -> we=1100, WD[31:16]=16'hCCDD. LWR off=2 with the same data -> we=0011, WD[15:0]=16'hAABB.
- Issue 4 loads back-to-back -> ld_issue_ready=0 on the cycle after the 4th. A 5th issue coincident with a response is refused. Responses write WR in issue order.
- Response coincident with alu_valid -> alu_ready=0, the load is written first, and the ALU value is written the following cycle. hz_rr1 equal to a queued wr -> hz_stall1=1 until the cycle after its write commits.
- Response with the queue empty -> err_orphan=1, reg_we stays 0. Reset mid-queue, then a response -> it is treated as an orphan.
